// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
//   Shared types and helpers for the pipelined add/subtract unit.
//   - op_e     : operation select carried on the op_sub input
//   - ovf_calc : two's-complement overflow from the three sign bits
// ---------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Overflow happens only when both addends share a sign and the result's
  // sign differs from it. The second operand is the already-inverted Bx in
  // subtract mode, so one rule covers add and subtract.
  function automatic logic ovf_calc(input logic a_msb,
                                    input logic bx_msb,
                                    input logic r_msb);
    return (a_msb == bx_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_adder_if
//   Operand/result stream bundle for pipelined_adder.
//   Input side : in_valid/in_ready handshake with A, B, Cin, op_sub.
//   Output side: out_valid/out_ready handshake with Result, Cout, Ovf.
//   master : the producer/consumer around the unit (drives operands, out_ready)
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface pipelined_adder_if #(
  parameter int SIZE = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] B;
  logic            Cin;
  logic            op_sub;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] Result;
  logic            Cout;
  logic            Ovf;

  modport master (
    output in_valid, A, B, Cin, op_sub, out_ready,
    input  in_ready, out_valid, Result, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, op_sub, out_ready,
    output in_ready, out_valid, Result, Cout, Ovf
  );

endinterface

// File: rtl/pipelined_adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
//   One registered W-bit slice of the carry chain.
//   clk, rst_n : clock, asynchronous active-low reset (clears sum and carry)
//   en         : load enable; the slice holds its value when low
//   a, b, cin  : slice operands and incoming carry
//   sum, cout  : registered slice sum and carry-out
// ---------------------------------------------------------------------------
module adder_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0]   total;
  logic [W-1:0] sum_d, sum_q;
  logic         cout_d, cout_q;

  always_comb begin
    total           = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    {cout_d, sum_d} = en ? total : {cout_q, sum_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   Pipelined SIZE-bit add/subtract unit with valid/ready streaming.
//   The carry chain is cut into STAGES slices of W = SIZE/STAGES bits; slice k
//   is computed in stage k. Operand bits not yet consumed ride along in skew
//   registers, finished low sum slices ride along in align registers, so the
//   whole result appears together at the last stage, STAGES cycles after the
//   beat was accepted.
//
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; discards every in-flight beat
//   bus    : slave side of pipelined_adder_if
//            in : in_valid, A, B, Cin, op_sub, out_ready
//            out: in_ready, out_valid, Result, Cout, Ovf
//
//   The whole pipe advances together (adv) whenever the output register is
//   empty or being drained; there is no bubble collapsing. Data registers only
//   load when a valid beat moves into them, so the output fields keep the last
//   delivered result while out_valid is low.
// ---------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int SIZE   = 32,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_adder_if.slave   bus
);

  localparam int W = SIZE / STAGES;

  if ((STAGES < 1) || (STAGES > SIZE) || ((SIZE % STAGES) != 0)) begin : g_param_check
    $error("pipelined_adder: STAGES must be in 1..SIZE and divide SIZE");
  end

  logic            adv;
  logic            out_vld;
  op_e             op;
  logic [SIZE-1:0] bx;
  logic            c0;

  // Subtract is A + ~B + 1; the incoming Cin is ignored in that mode.
  always_comb begin
    op = op_e'(bus.op_sub);
    bx = (op == OP_SUB) ? ~bus.B : bus.B;
    c0 = (op == OP_SUB) ? 1'b1 : bus.Cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operand bits still waiting for a later stage once this slice is done.
    localparam int UP_W = SIZE - (k + 1) * W;

    logic                 vld_in;
    logic                 en;
    logic [W-1:0]         a_sl;
    logic [W-1:0]         b_sl;
    logic                 cin;
    logic                 sa_in, sb_in;
    logic                 vld_d, vld_q;
    logic                 sa_d, sa_q;
    logic                 sb_d, sb_q;
    logic [W-1:0]         sum;
    logic                 cout;
    logic [(k+1)*W-1:0]   done;

    // Stage source: the bus for stage 0, the previous stage otherwise.
    if (k == 0) begin : g_src
      always_comb begin
        vld_in = bus.in_valid;
        a_sl   = bus.A[W-1:0];
        b_sl   = bx[W-1:0];
        cin    = c0;
        sa_in  = bus.A[SIZE-1];
        sb_in  = bx[SIZE-1];
      end
    end else begin : g_src
      always_comb begin
        vld_in = stg[k-1].vld_q;
        a_sl   = stg[k-1].g_up.a_up_q[W-1:0];
        b_sl   = stg[k-1].g_up.b_up_q[W-1:0];
        cin    = stg[k-1].cout;
        sa_in  = stg[k-1].sa_q;
        sb_in  = stg[k-1].sb_q;
      end
    end

    always_comb begin
      en    = adv && vld_in;
      vld_d = adv ? vld_in : vld_q;
      sa_d  = en ? sa_in : sa_q;
      sb_d  = en ? sb_in : sb_q;
    end

    adder_slice #(.W(W)) u_slice (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .a    (a_sl),
      .b    (b_sl),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sa_q  <= 1'b0;
        sb_q  <= 1'b0;
      end else begin
        vld_q <= vld_d;
        sa_q  <= sa_d;
        sb_q  <= sb_d;
      end
    end

    // Skew registers for the operand slices later stages still need.
    if (UP_W > 0) begin : g_up
      logic [UP_W-1:0] a_up_in, b_up_in;
      logic [UP_W-1:0] a_up_d, a_up_q;
      logic [UP_W-1:0] b_up_d, b_up_q;

      if (k == 0) begin : g_up_src
        always_comb begin
          a_up_in = bus.A[SIZE-1:W];
          b_up_in = bx[SIZE-1:W];
        end
      end else begin : g_up_src
        always_comb begin
          a_up_in = stg[k-1].g_up.a_up_q[SIZE-k*W-1:W];
          b_up_in = stg[k-1].g_up.b_up_q[SIZE-k*W-1:W];
        end
      end

      always_comb begin
        a_up_d = en ? a_up_in : a_up_q;
        b_up_d = en ? b_up_in : b_up_q;
      end

      always_ff @(posedge clk) begin
        a_up_q <= a_up_d;
        b_up_q <= b_up_d;
      end
    end

    // Align registers for the low sum slices finished in earlier stages;
    // reset so the last stage's Result reads zero out of reset.
    if (k > 0) begin : g_lo
      logic [k*W-1:0] lo_d, lo_q;

      always_comb begin
        lo_d = en ? stg[k-1].done : lo_q;
        done = {sum, lo_q};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lo_q <= '0;
        end else begin
          lo_q <= lo_d;
        end
      end
    end else begin : g_lo
      always_comb begin
        done = sum;
      end
    end
  end

  // Output stage boundary: last stage registers are the result registers.
  always_comb begin
    out_vld       = stg[STAGES-1].vld_q;
    adv           = !out_vld || bus.out_ready;
    bus.in_ready  = adv;
    bus.out_valid = out_vld;
    bus.Result    = stg[STAGES-1].done;
    bus.Cout      = stg[STAGES-1].cout;
    bus.Ovf       = ovf_calc(stg[STAGES-1].sa_q, stg[STAGES-1].sb_q,
                             stg[STAGES-1].done[SIZE-1]);
  end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  localparam int SIZE   = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [SIZE-1:0] res;
    logic            cout;
    logic            ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pipelined_adder_if #(.SIZE(SIZE)) bus ();

  pipelined_adder #(.SIZE(SIZE), .STAGES(STAGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint ia, ib, ic, sres;
    logic [63:0] usum;
    ia = longint'($signed(a));
    ib = longint'($signed(b));
    ic = cin ? 64'sd1 : 64'sd0;
    if (sub) begin
      sres   = ia - ib;
      e.res  = a - b;
      e.cout = (a >= b);
    end else begin
      sres   = ia + ib + ic;
      e.res  = a + b + {31'd0, cin};
      usum   = {32'd0, a} + {32'd0, b} + {63'd0, cin};
      e.cout = (usum >= 64'h1_0000_0000);
    end
    e.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.Result !== '0) begin
      failures++; $display("FAIL reset_result got=%h want=0", bus.Result);
    end
    checks++;
    if (bus.Cout !== 1'b0) begin
      failures++; $display("FAIL reset_cout got=%b want=0", bus.Cout);
    end
    checks++;
    if (bus.Ovf !== 1'b0) begin
      failures++; $display("FAIL reset_ovf got=%b want=0", bus.Ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
  endtask

  // One isolated beat: latency, result fields, and hold after delivery.
  task automatic run_one(input string name, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic cin, input logic sub, input logic [SIZE-1:0] exp_res,
                         input logic exp_cout, input logic exp_ovf);
    int n;
    bus.A = a; bus.B = b; bus.Cin = cin; bus.op_sub = sub;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (n != STAGES || !bus.out_valid) begin
      failures++;
      $display("FAIL %s_latency got=%0d valid=%b want=%0d", name, n, bus.out_valid, STAGES);
    end
    checks++;
    if (bus.Result !== exp_res) begin
      failures++; $display("FAIL %s_result got=%h want=%h", name, bus.Result, exp_res);
    end
    checks++;
    if (bus.Cout !== exp_cout) begin
      failures++; $display("FAIL %s_cout got=%b want=%b", name, bus.Cout, exp_cout);
    end
    checks++;
    if (bus.Ovf !== exp_ovf) begin
      failures++; $display("FAIL %s_ovf got=%b want=%b", name, bus.Ovf, exp_ovf);
    end
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Result !== exp_res || bus.Cout !== exp_cout
        || bus.Ovf !== exp_ovf) begin
      failures++;
      $display("FAIL %s_hold got valid=%b res=%h cout=%b ovf=%b want valid=0 res=%h cout=%b ovf=%b",
               name, bus.out_valid, bus.Result, bus.Cout, bus.Ovf, exp_res, exp_cout, exp_ovf);
    end
  endtask

  task automatic test_carry();
    run_one("carry_all", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_one("cin_add", 32'h0000_00FF, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
  endtask

  task automatic test_subtract();
    run_one("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
    run_one("sub_cin_ignored", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    run_one("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("ovf_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
  endtask

  function automatic logic [SIZE-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // 16 random beats, consumer stalls on cycles 6..9.
  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, last_out = -1;
    logic pending = 1'b0, prev_stall = 1'b0;
    logic in_acc, out_acc;
    logic [SIZE-1:0] held_res;
    logic held_cout, held_ovf;
    held_res = '0; held_cout = 1'b0; held_ovf = 1'b0;
    for (int c = 0; c < 80 && got < 16; c++) begin
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Result !== held_res || bus.Cout !== held_cout
            || bus.Ovf !== held_ovf) begin
          failures++;
          $display("FAIL stall_hold c=%0d got valid=%b res=%h cout=%b ovf=%b want valid=1 res=%h cout=%b ovf=%b",
                   c, bus.out_valid, bus.Result, bus.Cout, bus.Ovf, held_res, held_cout, held_ovf);
        end
      end
      bus.out_ready = !(c >= 6 && c <= 9);
      if (!pending && sent < 16) begin
        bus.A = pick_operand(); bus.B = pick_operand();
        bus.Cin = 1'($urandom_range(0, 1)); bus.op_sub = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1;
        pending = 1'b1;
      end else if (!pending) begin
        bus.in_valid = 1'b0;
      end
      #1;
      checks++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        failures++;
        $display("FAIL stream_in_ready c=%0d got=%b want=%b", c, bus.in_ready,
                 (!bus.out_valid || bus.out_ready));
      end
      in_acc  = bus.in_valid && bus.in_ready;
      out_acc = bus.out_valid && bus.out_ready;
      if (out_acc) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL stream_extra_beat c=%0d got res=%h want none", c, bus.Result);
        end else begin
          e = q.pop_front();
          if (bus.Result !== e.res || bus.Cout !== e.cout || bus.Ovf !== e.ovf) begin
            failures++;
            $display("FAIL stream_beat%0d got res=%h cout=%b ovf=%b want res=%h cout=%b ovf=%b",
                     got, bus.Result, bus.Cout, bus.Ovf, e.res, e.cout, e.ovf);
          end
        end
        got++;
        last_out = c;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held_res = bus.Result; held_cout = bus.Cout; held_ovf = bus.Ovf;
      if (in_acc) begin
        q.push_back(model(bus.A, bus.B, bus.Cin, bus.op_sub));
        sent++;
        pending = 1'b0;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got != 16 || q.size() != 0 || sent != 16) begin
      failures++;
      $display("FAIL stream_count got=%0d sent=%0d left=%0d want 16/16/0", got, sent, q.size());
    end
    // Full rate except the 4 stalled cycles: last beat leaves at 16+STAGES+4-1.
    checks++;
    if (last_out != 16 + STAGES + 4 - 1) begin
      failures++;
      $display("FAIL stream_throughput last_out_cycle=%0d want=%0d", last_out, 16 + STAGES + 4 - 1);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    idle_inputs();
    bus.out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      bus.A = $urandom; bus.B = $urandom; bus.Cin = 1'b1; bus.op_sub = 1'b0;
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL midrst_fill got valid=%b want=1", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Result !== '0 || bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got valid=%b res=%h cout=%b ovf=%b want all 0",
               bus.out_valid, bus.Result, bus.Cout, bus.Ovf);
    end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++; $display("FAIL midrst_stale got=%0d want=0", stale);
    end
    run_one("after_rst", 32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, 32'h0000_2345, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_carry();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
